// File: rtl/data_mem_ctrl.sv
// Byte-addressed data memory for the MIPS datapath: byte/half/word stores,
// sign/zero-extended loads, alignment and range checking, and a configurable
// read latency with a Ready / Read_valid handshake.
//
// state | meaning
// IDLE  | accepting requests; Ready=1
// BUSY  | multi-cycle read in flight; Ready=0, counting down to completion
module data_mem_ctrl #(
  parameter int    DEPTH        = 1024,
  parameter int    ADDR_W       = 32,
  parameter int    READ_LATENCY = 1,
  parameter string INIT_FILE    = ""
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] Address,
  input  logic [31:0]       Write_data,
  input  logic              Mem_read,
  input  logic              Mem_write,
  input  logic [1:0]        Size,
  input  logic              Unsigned,
  output logic [31:0]       Read_data,
  output logic              Read_valid,
  output logic              Ready,
  output logic              Error
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = (READ_LATENCY > 2) ? $clog2(READ_LATENCY) : 1;
  localparam bit SINGLE = (READ_LATENCY == 1);
  localparam logic [CNT_W-1:0]  CNT_INIT  = CNT_W'((READ_LATENCY > 1) ? READ_LATENCY - 2 : 0);
  localparam logic [ADDR_W-2:0] DEPTH_LIM = (ADDR_W-1)'(DEPTH);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state, next_state;
  logic [31:0]      mem [DEPTH];
  logic [CNT_W-1:0] cnt;

  logic             accept, acc_read, acc_write, complete;
  logic             bad_now, range_bad;
  logic [IDX_W-1:0] cur_idx;

  // Latched copy of a multi-cycle read request.
  logic [IDX_W-1:0] req_idx;
  logic [1:0]       req_lane, req_size;
  logic             req_uns, req_bad;

  // Load path operands: live inputs for single-cycle reads, latched otherwise.
  logic [IDX_W-1:0] sel_idx;
  logic [1:0]       sel_lane, sel_size;
  logic             sel_uns, sel_bad;

  logic [31:0]      rd_word, load_val, wr_lanes;
  logic [15:0]      rd_half;
  logic [7:0]       rd_byte;
  logic [3:0]       byte_en;

  assign Ready     = (state == IDLE);
  assign accept    = Ready && (Mem_read || Mem_write) && !Reset;
  assign acc_read  = accept && Mem_read;
  assign acc_write = accept && !Mem_read && Mem_write;
  assign cur_idx   = Address[IDX_W+1:2];
  assign range_bad = ({1'b0, Address[ADDR_W-1:2]} >= DEPTH_LIM);

  assign sel_idx  = SINGLE ? cur_idx      : req_idx;
  assign sel_lane = SINGLE ? Address[1:0] : req_lane;
  assign sel_size = SINGLE ? Size         : req_size;
  assign sel_uns  = SINGLE ? Unsigned     : req_uns;
  assign sel_bad  = SINGLE ? bad_now      : req_bad;

  // Request legality: range first, then size/alignment.
  always_comb begin
    case (Size)
      2'b00:   bad_now = range_bad;
      2'b01:   bad_now = range_bad || Address[0];
      2'b10:   bad_now = range_bad || (Address[1:0] != 2'b00);
      default: bad_now = 1'b1;
    endcase
  end

  // Store lane enables and lane-replicated write data.
  always_comb begin
    byte_en  = 4'b0000;
    wr_lanes = Write_data;
    case (Size)
      2'b00: begin
        byte_en  = 4'b0001 << Address[1:0];
        wr_lanes = {4{Write_data[7:0]}};
      end
      2'b01: begin
        byte_en  = Address[1] ? 4'b1100 : 4'b0011;
        wr_lanes = {2{Write_data[15:0]}};
      end
      2'b10:   byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
  end

  // Memory array: only enabled lanes of a legal store change.
  always_ff @(posedge Clk) begin
    if (acc_write && !bad_now) begin
      for (int k = 0; k < 4; k++) begin
        if (byte_en[k]) mem[cur_idx][8*k +: 8] <= wr_lanes[8*k +: 8];
      end
    end
  end

  // Lane selection and sign/zero extension of the load result.
  always_comb begin
    rd_word  = sel_bad ? 32'h0 : mem[sel_idx];
    rd_half  = sel_lane[1] ? rd_word[31:16] : rd_word[15:0];
    rd_byte  = rd_word[{sel_lane, 3'b000} +: 8];
    case (sel_size)
      2'b00:   load_val = sel_uns ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
      2'b01:   load_val = sel_uns ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
      default: load_val = rd_word;
    endcase
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next state and read completion.
  always_comb begin
    next_state = state;
    complete   = 1'b0;
    case (state)
      IDLE: begin
        if (acc_read) begin
          if (SINGLE) complete   = 1'b1;
          else        next_state = BUSY;
        end
      end
      BUSY: begin
        if (cnt == '0) begin
          complete   = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Output registers, latency counter and request capture.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Read_data  <= 32'h0;
      Read_valid <= 1'b0;
      Error      <= 1'b0;
      cnt        <= '0;
      req_idx    <= '0;
      req_lane   <= 2'b00;
      req_size   <= 2'b00;
      req_uns    <= 1'b0;
      req_bad    <= 1'b0;
    end else begin
      Read_valid <= complete;
      Error      <= (acc_write && bad_now) || (complete && sel_bad);
      if (complete) Read_data <= sel_bad ? 32'h0 : load_val;
      if (acc_read) begin
        req_idx  <= cur_idx;
        req_lane <= Address[1:0];
        req_size <= Size;
        req_uns  <= Unsigned;
        req_bad  <= bad_now;
      end
      if (state == BUSY && cnt != '0) cnt <= cnt - 1'b1;
      else if (acc_read)              cnt <= CNT_INIT;
    end
  end

endmodule
